glip_channel_fifo: RTL and testbench
====================================

# glip_channel_fifo

Synchronous first-word-fall-through FIFO between two 16-bit GLIP channels. It sits between a producer driving a `glip_channel` master and a consumer taking a `glip_channel` slave, and decouples them in time. It absorbs bursts up to DEPTH words, preserves word order and data exactly, and exports its fill level and watermark flags for flow-control logic.

## Interface
- WIDTH, 16, data width; must equal the WIDTH of both attached `glip_channel` instances.
- DEPTH, 16, number of storage entries; power of two, minimum 2.
- ALMOST_FULL_THRESHOLD, DEPTH-2, level at or above which `almost_full` is asserted; legal range 1..DEPTH.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in  glip_channel.slave  WIDTH+2  write side: data/valid in, ready out.
- out  glip_channel.master  WIDTH+2  read side: data/valid out, ready in.
- level  output  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH.
- empty  output  1  high when level == 0.
- full  output  1  high when level == DEPTH.
- almost_full  output  1  high when level >= ALMOST_FULL_THRESHOLD.

## Operation
- Push: `in.valid && in.ready` at a rising edge writes `in.data` to mem[wr_ptr]; wr_ptr increments.
- Pop: `out.valid && out.ready` at a rising edge consumes mem[rd_ptr]; rd_ptr increments.
- `in.ready` = !full. `out.valid` = !empty. `out.data` = mem[rd_ptr] (first-word-fall-through).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case. `level` is a separate counter.
- Level update per edge:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Push and pop in the same cycle are always legal when both handshakes complete.
  - When empty, no pop can occur (`out.valid` = 0), so there is no same-cycle bypass.
  - When full, no push can occur.
- No overflow or underflow is possible by construction. Assertions in simulation check that `level` stays within 0..DEPTH.
- Rules the module relies on from its neighbours:
  - The producer holds `in.data` and `in.valid` stable until the handshake completes.
  - The consumer may deassert `out.ready` at any time.
  - The FIFO itself never drops `out.valid` or changes `out.data` while a word is pending and not popped.
- Reset:
  - Asserting `rst` clears both pointers and `level` immediately (asynchronous), so `out.valid` = 0, `in.ready` = 1, `empty` = 1, `full` = 0, `almost_full` = 0.
  - Memory contents are not reset. `out.data` is don't-care while empty.
  - Reset mid-burst discards all stored words. The first push after deassertion is the first word out.

## Timing
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on `out.data` with `out.valid` = 1 after edge N (cycle N+1), if it was the only entry.
- `full`, `empty`, `almost_full` and `level` are registered or derived only from registered `level`. They reflect all handshakes up to the previous edge.
- `in.ready` and `out.valid` have no combinational path from `in.valid` or `out.ready`.
- Sustained throughput is 1 word/cycle in both directions at any level 1..DEPTH−1.
- Reset deassertion is synchronous to `clk` at the system level. The first legal push is at the first edge with `rst` low.

## Structure
- Shared package `glip_pkg`: `GLIP_DATA_WIDTH` = 16 and a function `glip_level_width(depth)` returning $clog2(depth)+1.
- Sub-module `glip_fifo_mem`: a DEPTH×WIDTH register array with one write port and one asynchronous read port.
- The top level holds the pointers, level counter, flags and handshake logic.

## Test plan
- Reset then single word: push 0xA5A5 at cycle 1 -> `out.valid` = 1 and `out.data` = 0xA5A5 at cycle 2, `level` = 1; pop -> `empty` = 1 at cycle 3.
- Fill: push 16 words 0x0000..0x000F with `out.ready` = 0 -> `almost_full` rises when `level` = 14, `full` and `in.ready` = 0 when `level` = 16; further `in.valid` is ignored.
- Streaming: `in.valid` = `out.ready` = 1 for 100 cycles with an incrementing pattern -> `level` steady at 1, output equals input delayed 1 cycle, no gaps.
- Wrap-around with random stalls: 1000 random words, random `in.valid` and `out.ready` at 50% each -> scoreboard matches order and data exactly; `level` never exceeds 16.
- Simultaneous push and pop at `level` = 16 after one pop frees a slot, and at `level` = 1 -> `level` unchanged, data order preserved.
- Mid-burst reset: `level` = 7, assert `rst` mid-cycle -> outputs go to their reset values before the next edge; after release, push 0x1234 -> first output is 0x1234.

Source files
------------

// File: rtl/glip_pkg.sv
// rtl/glip_pkg.sv - shared GLIP channel width and level-width helper
package glip_pkg;

  localparam int GLIP_DATA_WIDTH = 16;

  // A level counter must hold 0..depth inclusive, one bit wider than a pointer.
  function automatic int glip_level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/glip_channel.sv
// rtl/glip_channel.sv - valid/ready word channel between GLIP blocks
interface glip_channel #(
  parameter int WIDTH = glip_pkg::GLIP_DATA_WIDTH
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/glip_fifo_mem.sv
// rtl/glip_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read
module glip_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  // Storage is deliberately left unreset; occupancy is tracked outside.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/glip_channel_fifo.sv
// rtl/glip_channel_fifo.sv - first-word-fall-through FIFO between two GLIP channels
module glip_channel_fifo
  import glip_pkg::*;
#(
  parameter int WIDTH                 = GLIP_DATA_WIDTH,
  parameter int DEPTH                 = 16,
  parameter int ALMOST_FULL_THRESHOLD = DEPTH - 2
) (
  input  logic                               clk,
  input  logic                               rst,
  glip_channel.slave                         in,
  glip_channel.master                        out,
  output logic [glip_level_width(DEPTH)-1:0] level,
  output logic                               empty,
  output logic                               full,
  output logic                               almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = glip_level_width(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(ALMOST_FULL_THRESHOLD);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Flags come only from the registered level, so ready/valid never depend
  // combinationally on the partner's valid/ready.
  assign empty       = (level == '0);
  assign full        = (level == FULL_LEVEL);
  assign almost_full = (level >= AF_LEVEL);

  assign in.ready  = !full;
  assign out.valid = !empty;

  assign push = in.valid && !full;
  assign pop  = out.ready && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  glip_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in.data),
    .raddr (rd_ptr),
    .rdata (out.data)
  );

  level_in_range: assert property (@(posedge clk) disable iff (rst) level <= FULL_LEVEL);

endmodule

// File: tb/tb_glip_channel_fifo.sv
// tb/tb_glip_channel_fifo.sv - randomized scoreboard bench for glip_channel_fifo
module tb_glip_channel_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        almost_full;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q[$];

  glip_channel #(.WIDTH(16)) ch_in ();
  glip_channel #(.WIDTH(16)) ch_out ();

  glip_channel_fifo #(
    .WIDTH                 (16),
    .DEPTH                 (16),
    .ALMOST_FULL_THRESHOLD (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (ch_in),
    .out         (ch_out),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  // Reference: a 16-entry queue; a push is taken when not full, a pop when not empty.
  task automatic tick();
    int  sz;
    bit  do_push;
    bit  do_pop;
    sz      = q.size();
    do_push = ch_in.valid && (sz < 16);
    do_pop  = ch_out.ready && (sz > 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(ch_in.data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ch_in.valid  = 1'b0;
    ch_in.data   = '0;
    ch_out.ready = 1'b0;
    rst          = 1'b1;
    #1;
    n_checks++; if (ch_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", ch_out.valid); end
    n_checks++; if (ch_in.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", ch_in.ready); end
    n_checks++; if ({empty, full, almost_full} !== 3'b100) begin n_fail++; $display("FAIL reset_flags got %b want 100", {empty, full, almost_full}); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_single_word();
    ch_in.data  = 16'hA5A5;
    ch_in.valid = 1'b1;
    tick();
    ch_in.valid = 1'b0;
    n_checks++; if (ch_out.valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", ch_out.valid); end
    n_checks++; if (ch_out.data !== 16'hA5A5) begin n_fail++; $display("FAIL single_data got %h want a5a5", ch_out.data); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
    ch_out.ready = 1'b1;
    tick();
    ch_out.ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0b want 1", empty); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_level_after_pop got %0d want 0", level); end
  endtask

  task automatic test_fill();
    ch_out.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ch_in.data  = 16'(i);
      ch_in.valid = 1'b1;
      tick();
      n_checks++; if (level !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_level got %0d want %0d", level, i + 1); end
      n_checks++; if (almost_full !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_almost_full at %0d got %0b want %0b", i + 1, almost_full, i + 1 >= 14); end
      n_checks++; if (full !== (i + 1 == 16)) begin n_fail++; $display("FAIL fill_full at %0d got %0b want %0b", i + 1, full, i + 1 == 16); end
      n_checks++; if (ch_in.ready !== (i + 1 != 16)) begin n_fail++; $display("FAIL fill_in_ready at %0d got %0b want %0b", i + 1, ch_in.ready, i + 1 != 16); end
    end
    ch_in.data = 16'hDEAD;
    repeat (3) tick();
    ch_in.valid = 1'b0;
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_overpush_level got %0d want 16", level); end
    n_checks++; if (ch_out.data !== 16'h0000) begin n_fail++; $display("FAIL fill_head_data got %h want 0000", ch_out.data); end
  endtask

  task automatic test_simultaneous();
    // Starts full: the first both-sides cycle can only pop, then push+pop hold level.
    ch_in.valid  = 1'b1;
    ch_out.ready = 1'b1;
    ch_in.data   = 16'h0100;
    tick();
    n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL simul_full_pop_level got %0d want 15", level); end
    for (int k = 1; k <= 4; k++) begin
      ch_in.data = 16'h0100 + 16'(k);
      tick();
      n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL simul_hi_level got %0d want 15", level); end
      n_checks++; if (ch_out.data !== q[0]) begin n_fail++; $display("FAIL simul_hi_data got %h want %h", ch_out.data, q[0]); end
    end
    ch_in.valid = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      n_checks++; if (ch_out.data !== q[0]) begin n_fail++; $display("FAIL simul_drain_data got %h want %h", ch_out.data, q[0]); end
      tick();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_drained_empty got %0b want 1", empty); end
    ch_out.ready = 1'b0;
    ch_in.valid  = 1'b1;
    ch_in.data   = 16'h0200;
    tick();
    ch_out.ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      ch_in.data = 16'h0200 + 16'(k);
      tick();
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL simul_lo_level got %0d want 1", level); end
      n_checks++; if (ch_out.data !== 16'h0200 + 16'(k)) begin n_fail++; $display("FAIL simul_lo_data got %h want %h", ch_out.data, 16'h0200 + 16'(k)); end
    end
    ch_in.valid = 1'b0;
    tick();
    ch_out.ready = 1'b0;
  endtask

  task automatic test_streaming();
    ch_in.valid  = 1'b1;
    ch_out.ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      ch_in.data = 16'h2000 + 16'(k);
      tick();
      n_checks++; if (level !== 5'd1 || ch_out.valid !== 1'b1) begin n_fail++; $display("FAIL stream_level got %0d/%0b want 1/1", level, ch_out.valid); end
      n_checks++; if (ch_out.data !== 16'h2000 + 16'(k)) begin n_fail++; $display("FAIL stream_data got %h want %h", ch_out.data, 16'h2000 + 16'(k)); end
    end
    ch_in.valid = 1'b0;
    tick();
    ch_out.ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_end_empty got %0b want 1", empty); end
  endtask

  task automatic test_random_wrap();
    int sent = 0;
    int max_level = 0;
    bit acc;
    ch_in.valid  = 1'b0;
    for (int cyc = 0; cyc < 8000 && (sent < 1000 || q.size() > 0); cyc++) begin
      if (!ch_in.valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        ch_in.data  = 16'($urandom);
        ch_in.valid = 1'b1;
      end
      ch_out.ready = ($urandom_range(0, 1) == 1);
      acc = ch_in.valid && (q.size() < 16);
      tick();
      if (acc) begin
        sent++;
        ch_in.valid = 1'b0;
      end
      if (q.size() > max_level) max_level = q.size();
      n_checks++; if (level !== 5'(q.size())) begin n_fail++; $display("FAIL rand_level got %0d want %0d", level, q.size()); end
      n_checks++; if (ch_out.valid !== (q.size() > 0) || ch_in.ready !== (q.size() < 16)) begin n_fail++; $display("FAIL rand_handshake got v%0b r%0b want v%0b r%0b", ch_out.valid, ch_in.ready, q.size() > 0, q.size() < 16); end
      if (q.size() > 0) begin
        n_checks++; if (ch_out.data !== q[0]) begin n_fail++; $display("FAIL rand_data got %h want %h", ch_out.data, q[0]); end
      end
    end
    ch_out.ready = 1'b0;
    n_checks++; if (sent != 1000 || q.size() != 0) begin n_fail++; $display("FAIL rand_completion got sent=%0d left=%0d want sent=1000 left=0", sent, q.size()); end
    n_checks++; if (level > 5'd16) begin n_fail++; $display("FAIL rand_level_bound got %0d want <=16 (model max %0d)", level, max_level); end
  endtask

  task automatic test_mid_reset();
    ch_out.ready = 1'b0;
    ch_in.valid  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ch_in.data = 16'h3000 + 16'(k);
      tick();
    end
    ch_in.valid = 1'b0;
    n_checks++; if (level !== 5'd7) begin n_fail++; $display("FAIL midrst_pre_level got %0d want 7", level); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (level !== 5'd0 || ch_out.valid !== 1'b0 || ch_in.ready !== 1'b1) begin n_fail++; $display("FAIL midrst_async got lvl=%0d v=%0b r=%0b want 0/0/1", level, ch_out.valid, ch_in.ready); end
    n_checks++; if ({empty, full, almost_full} !== 3'b100) begin n_fail++; $display("FAIL midrst_flags got %b want 100", {empty, full, almost_full}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    ch_in.data  = 16'h1234;
    ch_in.valid = 1'b1;
    tick();
    ch_in.valid = 1'b0;
    n_checks++; if (ch_out.valid !== 1'b1 || ch_out.data !== 16'h1234) begin n_fail++; $display("FAIL midrst_first_word got v=%0b d=%h want 1/1234", ch_out.valid, ch_out.data); end
    n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL midrst_level got %0d want 1", level); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_simultaneous();
    test_streaming();
    test_random_wrap();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
